// File: rtl/imem_access_ctrl.sv
// Access sequencer for the single-port instruction memory: arbitrates fetch reads against
// loader writes and generates a registered write-enable pulse with address/data setup and hold.
module imem_access_ctrl #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 32,
  parameter int unsigned WE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  inout  wire  [DW-1:0] mem_data
);

  localparam int unsigned CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] wdata_q;
  logic          drive_q;
  logic          last_ld_q;  // 1 = loader won the most recent grant
  logic          if_elig;
  logic          pick_ld;
  logic          pick_if;

  // Fetch is locked out during boot; on contention the previous loser wins.
  always_comb begin
    if_elig = if_req && !boot;
    pick_ld = ld_req && (!if_elig || !last_ld_q);
    pick_if = if_elig && !pick_ld;
  end

  assign mem_data = drive_q ? wdata_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      last_ld_q <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ld_gnt    <= 1'b0;
      ld_done   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ld_gnt    <= 1'b0;
      ld_done   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_ld) begin
            state_q   <= StWrSetup;
            ld_gnt    <= 1'b1;
            mem_addr  <= ld_addr;
            wdata_q   <= ld_wdata;
            drive_q   <= 1'b1;
            last_ld_q <= 1'b1;
          end else if (pick_if) begin
            state_q   <= StRd;
            if_gnt    <= 1'b1;
            mem_addr  <= if_addr;
            last_ld_q <= 1'b0;
          end
        end
        StRd: begin
          if_rdata  <= mem_data;
          if_rvalid <= 1'b1;
          state_q   <= StIdle;
        end
        StWrSetup: begin
          mem_we  <= 1'b1;
          cnt_q   <= CW'(WE_CYCLES - 1);
          state_q <= StWrPulse;
        end
        StWrPulse: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            mem_we  <= 1'b0;
            state_q <= StWrHold;
          end
        end
        StWrHold: begin
          ld_done <= 1'b1;
          drive_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl with a behavioural single-port memory on the bus.
module tb_imem_access_ctrl;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned WEC = 3;
  localparam byte GL = 8'd76;  // 'L'
  localparam byte GF = 8'd70;  // 'F'

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          boot = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt;
  logic          ld_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  wire  [DW-1:0] mem_data;

  imem_access_ctrl #(
    .AW       (AW),
    .DW       (DW),
    .WE_CYCLES(WEC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .boot     (boot),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_gnt   (ld_gnt),
    .ld_done  (ld_done),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Memory model drives the bus only in the read cycle; shadow holds the bench's expectation.
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  assign mem_data = if_gnt ? mem[mem_addr] : 'z;

  initial forever begin
    @(negedge clk);
    if (mem_we) mem[mem_addr] = mem_data;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            t;
  } wr_t;

  byte           gnt_q [$];
  logic [DW-1:0] rd_q  [$];
  wr_t           wr_q  [$];

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    int            cyc = 0;
    int            we_run = 0;
    logic          prev_we = 1'b0;
    logic          wr_active = 1'b0;
    logic [AW-1:0] wr_a = '0;
    logic [DW-1:0] wr_d = '0;
    byte           e;
    wr_t           w;
    logic [DW-1:0] r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_q.delete();
        rd_q.delete();
        wr_active = 1'b0;
        we_run    = 0;
        prev_we   = 1'b0;
      end else begin
        cyc++;
        if (if_gnt || ld_gnt) begin
          check("gnt_exclusive", 64'(if_gnt & ld_gnt), 64'd0);
          if (gnt_q.size() == 0) begin
            check("unexpected_grant", 64'd1, 64'd0);
          end else begin
            e = gnt_q.pop_front();
            check("grant_order", 64'(ld_gnt ? GL : GF), 64'(e));
          end
        end
        if (if_gnt) begin
          check("rd_addr", 64'(mem_addr), 64'(if_addr));
          rd_q.push_back(shadow[if_addr]);
        end
        if (if_rvalid) begin
          if (rd_q.size() == 0) begin
            check("unexpected_rvalid", 64'd1, 64'd0);
          end else begin
            r = rd_q.pop_front();
            check("rd_data_sb", 64'(if_rdata), 64'(r));
          end
        end
        if (ld_gnt) begin
          check("we_low_at_setup", 64'(mem_we), 64'd0);
          w.a = ld_addr;
          w.d = ld_wdata;
          w.t = cyc;
          wr_q.push_back(w);
          shadow[ld_addr] = ld_wdata;
          wr_active = 1'b1;
          wr_a = ld_addr;
          wr_d = ld_wdata;
        end
        if (wr_active && !ld_done) begin
          check("wr_addr_stable", 64'(mem_addr), 64'(wr_a));
          check("wr_data_stable", 64'(mem_data), 64'(wr_d));
        end
        if (mem_we) begin
          we_run++;
          check("we_in_window", 64'(wr_active), 64'd1);
        end else if (we_run != 0) begin
          check("we_width", 64'(we_run), 64'(WEC));
          we_run = 0;
        end
        if (ld_done) begin
          check("we_low_at_hold", 64'(prev_we), 64'd0);
          if (wr_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            w = wr_q.pop_front();
            check("done_latency", 64'(cyc - w.t), 64'(WEC + 2));
            check("mem_written", 64'(mem[w.a]), 64'(w.d));
          end
          wr_active = 1'b0;
        end
        prev_we = mem_we;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int n, input string tag);
    int got = 0;
    for (int i = 0; i < 100 && got < n; i++) begin
      tick();
      if (if_gnt || ld_gnt) got++;
    end
    if (got < n) check({tag, "_timeout"}, 64'(got), 64'(n));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_addr  = a;
    ld_wdata = d;
    gnt_q.push_back(GL);
    ld_req = 1'b1;
    wait_gnt(1, "wr_gnt");
    ld_req = 1'b0;
    repeat (WEC + 4) tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    if_addr = a;
    gnt_q.push_back(GF);
    if_req = 1'b1;
    wait_gnt(1, "rd_gnt");
    if_req = 1'b0;
    tick();
    check("rd_rvalid", 64'(if_rvalid), 64'd1);
    check("rd_data", 64'(if_rdata), 64'(exp));
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_gnt"}, 64'(if_gnt), 64'd0);
    check({tag, "_if_rvalid"}, 64'(if_rvalid), 64'd0);
    check({tag, "_ld_gnt"}, 64'(ld_gnt), 64'd0);
    check({tag, "_ld_done"}, 64'(ld_done), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = 32'hA500_0000 ^ i;
      shadow[i] = 32'hA500_0000 ^ i;
    end
    mem[5]    = 32'h1234_5678;
    shadow[5] = 32'h1234_5678;

    // Reset values
    repeat (3) tick();
    check_quiet("reset");
    rst_n = 1'b1;

    // 1: single fetch, exact latency
    if_addr = 10'h005;
    gnt_q.push_back(GF);
    if_req = 1'b1;
    tick();
    check("t1_if_gnt", 64'(if_gnt), 64'd1);
    check("t1_mem_we", 64'(mem_we), 64'd0);
    if_req = 1'b0;
    tick();
    check("t1_rvalid", 64'(if_rvalid), 64'd1);
    check("t1_rdata", 64'(if_rdata), 64'h1234_5678);
    check("t1_mem_we2", 64'(mem_we), 64'd0);
    tick();

    // 2: boot-phase write to top word, then read it back
    boot = 1'b1;
    do_write(10'h3FF, 32'hDEAD_BEEF);
    boot = 1'b0;
    do_read(10'h3FF, 32'hDEAD_BEEF);

    // 3: boot locks out fetch; fetch wins once boot drops
    boot     = 1'b1;
    ld_addr  = 10'h010;
    ld_wdata = 32'h1111_0000;
    if_addr  = 10'h020;
    gnt_q.push_back(GL);
    gnt_q.push_back(GL);
    ld_req = 1'b1;
    if_req = 1'b1;
    wait_gnt(2, "t3_boot");
    boot = 1'b0;
    gnt_q.push_back(GF);
    wait_gnt(1, "t3_release");
    if_req = 1'b0;
    ld_req = 1'b0;
    repeat (WEC + 4) tick();

    // 4: round-robin from reset, loader first
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    ld_addr  = 10'h030;
    ld_wdata = 32'h2222_3333;
    if_addr  = 10'h040;
    gnt_q.push_back(GL);
    gnt_q.push_back(GF);
    gnt_q.push_back(GL);
    gnt_q.push_back(GF);
    ld_req = 1'b1;
    if_req = 1'b1;
    wait_gnt(4, "t4_rr");
    ld_req = 1'b0;
    if_req = 1'b0;
    repeat (WEC + 4) tick();

    // 5: asynchronous reset in the middle of the write pulse
    ld_addr  = 10'h100;
    ld_wdata = 32'hCAFE_F00D;
    gnt_q.push_back(GL);
    ld_req = 1'b1;
    wait_gnt(1, "t5_gnt");
    ld_req = 1'b0;
    tick();
    check("t5_we_high", 64'(mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_quiet("t5_async");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_quiet("t5_after");
    do_read(10'h005, 32'h1234_5678);
    repeat (3) tick();

    check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
